traj_action_decoder: RTL and testbench

Streaming decoder for the 8x8 gridworld. It takes a sequence of observed (x, y) positions and recovers the 3-bit action code for each step under the gridworld step semantics. It packs STEPS consecutive codes into one action word in the same bit layout the trajectory/spec-checking logic consumes. It sits between a position source (logged demonstrations, DUT trace) and the spec-inference datapath that replays action words.

---
 rtl/traj_action_decoder.sv | 147 ++++++++++++++
 tb/tb_traj_action_decoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traj_action_decoder.sv
// Recovers gridworld action codes from a stream of (x,y) positions and packs STEPS codes per word.
// One-cycle decode; word held until out_ready, samples refused while a word is held.
module traj_action_decoder #(
  parameter int STEPS = 4,
  localparam int W  = 3 * STEPS,
  localparam int KW = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_start,
  input  logic [2:0]    in_x,
  input  logic [2:0]    in_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_word,
  output logic          out_err,
  output logic [KW-1:0] out_err_step
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_px;
  logic [2:0]    r_py;
  logic [KW-1:0] r_k;
  logic [W-1:0]  r_word;
  logic          r_err;
  logic [KW-1:0] r_err_step;
  logic          w_acc;
  logic [2:0]    w_code;
  logic          w_match;

  // Axis move: dir 0 = stay, 1 = increment, 2 = decrement; both saturate at the grid edge.
  function automatic logic [2:0] axis_step(input logic [2:0] v, input logic [1:0] dir);
    case (dir)
      2'd1:    return (v == 3'd7) ? v : v + 3'd1;
      2'd2:    return (v == 3'd0) ? v : v - 3'd1;
      default: return v;
    endcase
  endfunction

  function automatic logic [1:0] x_dir(input logic [2:0] c);
    if (c[1:0] == 2'd0) return 2'd0;
    return c[2] ? 2'd2 : 2'd1;
  endfunction

  function automatic logic [1:0] y_dir(input logic [2:0] c);
    case (c)
      3'd2, 3'd6:       return 2'd0;
      3'd7, 3'd0, 3'd1: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

  assign w_acc = in_valid && (r_state != S_HOLD);

  // Scan codes high to low so the lowest matching code is the one left standing.
  always_comb begin
    w_code  = 3'd0;
    w_match = 1'b0;
    for (int c = 7; c >= 0; c--) begin
      if (axis_step(r_px, x_dir(3'(c))) == in_x && axis_step(r_py, y_dir(3'(c))) == in_y) begin
        w_code  = 3'(c);
        w_match = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_acc && in_start) w_state_nxt = S_COLLECT;
      S_COLLECT: if (w_acc && !in_start && r_k == KW'(STEPS - 1)) w_state_nxt = S_HOLD;
      S_HOLD:    if (out_ready) w_state_nxt = S_COLLECT;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid    = (r_state == S_HOLD);
    in_ready     = (r_state != S_HOLD);
    out_word     = r_word;
    out_err      = r_err;
    out_err_step = r_err_step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_px       <= 3'd0;
      r_py       <= 3'd0;
      r_k        <= '0;
      r_word     <= '0;
      r_err      <= 1'b0;
      r_err_step <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc && in_start) begin
            r_px       <= in_x;
            r_py       <= in_y;
            r_k        <= '0;
            r_err      <= 1'b0;
            r_err_step <= '0;
          end
        end
        S_COLLECT: begin
          if (w_acc) begin
            r_px <= in_x;
            r_py <= in_y;
            if (in_start) begin
              r_k        <= '0;
              r_err      <= 1'b0;
              r_err_step <= '0;
            end else begin
              // Step 0 lands in the top three bits of the word.
              for (int s = 0; s < STEPS; s++) begin
                if (r_k == KW'(s)) r_word[W-3-3*s +: 3] <= w_match ? w_code : 3'd0;
              end
              if (!w_match) begin
                r_err <= 1'b1;
                if (!r_err) r_err_step <= r_k;
              end
              r_k <= (r_k == KW'(STEPS - 1)) ? '0 : r_k + KW'(1);
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_k        <= '0;
            r_err      <= 1'b0;
            r_err_step <= '0;
          end
        end
        default: r_k <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_traj_action_decoder.sv
// Bench for traj_action_decoder: directed vector table, hand sequences, and random traffic vs a reference model.
module tb_traj_action_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_start;
  logic [2:0]  in_x;
  logic [2:0]  in_y;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_word;
  logic        out_err;
  logic [1:0]  out_err_step;

  always #5 clk = ~clk;

  traj_action_decoder #(.STEPS(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_start(in_start),
    .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_err(out_err), .out_err_step(out_err_step)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: per-code displacement tables and plain clamped arithmetic.
  int DX [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int DY [8] = '{1, 1, 0, -1, -1, -1, 0, 1};

  function automatic int clamp7(input int v);
    return (v < 0) ? 0 : ((v > 7) ? 7 : v);
  endfunction

  function automatic int ref_code(input int px, input int py, input int nx, input int ny);
    for (int c = 0; c < 8; c++)
      if (clamp7(px + DX[c]) == nx && clamp7(py + DY[c]) == ny) return c;
    return -1;
  endfunction

  bit          m_have, m_hold, m_err;
  int          m_px, m_py, m_step;
  int          m_codes [$];
  logic [11:0] m_word;

  task automatic model_check();
    chk("mdl_in_ready", 32'(in_ready), 32'(!m_hold));
    chk("mdl_out_valid", 32'(out_valid), 32'(m_hold));
    if (m_hold) begin
      chk("mdl_word", 32'(out_word), 32'(m_word));
      chk("mdl_err", 32'(out_err), 32'(m_err));
      chk("mdl_err_step", 32'(out_err_step), 32'(m_step));
    end
  endtask

  task automatic model_update();
    int c;
    if (rst) begin
      m_have = 0; m_hold = 0; m_codes.delete();
    end else if (m_hold) begin
      if (out_ready) begin m_hold = 0; m_codes.delete(); end
    end else if (in_valid) begin
      if (in_start) begin
        m_have = 1; m_px = int'(in_x); m_py = int'(in_y); m_codes.delete();
      end else if (m_have) begin
        m_codes.push_back(ref_code(m_px, m_py, int'(in_x), int'(in_y)));
        m_px = int'(in_x); m_py = int'(in_y);
        if (m_codes.size() == 4) begin
          m_word = '0; m_err = 0; m_step = 0;
          for (int i = 0; i < 4; i++) begin
            c = m_codes[i];
            if (c < 0) begin
              if (!m_err) m_step = i;
              m_err = 1; c = 0;
            end
            m_word = m_word | (12'(c) << (3 * (3 - i)));
          end
          m_hold = 1;
          m_codes.delete();
        end
      end
    end
  endtask

  task automatic step();
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input bit v, input bit s, input int x, input int y, input bit ordy);
    in_valid = v; in_start = s; in_x = 3'(x); in_y = 3'(y); out_ready = ordy;
  endtask

  task automatic send(input bit s, input int x, input int y);
    drive(1, s, x, y, 0);
    step();
  endtask

  task automatic handshake(input string name);
    drive(0, 0, 0, 0, 1);
    step();
    chk({name, "_rdy_back"}, 32'(in_ready), 32'd1);
    chk({name, "_vld_drop"}, 32'(out_valid), 32'd0);
    out_ready = 1'b0;
  endtask

  typedef struct {
    int          ox, oy;
    int          xs [4];
    int          ys [4];
    logic [11:0] word;
    logic        err;
    logic [1:0]  estep;
  } vec_t;

  function automatic vec_t mk(input int ox, input int oy,
                              input int x0, input int y0, input int x1, input int y1,
                              input int x2, input int y2, input int x3, input int y3,
                              input logic [11:0] w, input logic e, input logic [1:0] es);
    vec_t v;
    v.ox = ox; v.oy = oy;
    v.xs[0] = x0; v.xs[1] = x1; v.xs[2] = x2; v.xs[3] = x3;
    v.ys[0] = y0; v.ys[1] = y1; v.ys[2] = y2; v.ys[3] = y3;
    v.word = w; v.err = e; v.estep = es;
    return v;
  endfunction

  vec_t vt [6];
  int   gx, gy, rc;

  initial begin
    // Expected words computed by hand: step 0 occupies bits [11:9].
    vt[0] = mk(3, 0, 4, 1, 5, 1, 6, 0, 6, 0, 12'h29C, 1'b0, 2'd0); // codes 1,2,3,4
    vt[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h924, 1'b0, 2'd0); // corner stay -> 4
    vt[2] = mk(7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 12'h000, 1'b0, 2'd0); // corner stay -> 0
    vt[3] = mk(3, 3, 4, 4, 6, 4, 5, 5, 0, 0, 12'h238, 1'b1, 2'd1); // 1,bad,7,bad
    vt[4] = mk(7, 0, 7, 0, 6, 1, 6, 1, 5, 2, 12'h5C7, 1'b1, 2'd2); // 2,7,bad,7
    vt[5] = mk(2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 12'h000, 1'b1, 2'd0); // interior stay illegal

    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_have = 0; m_hold = 0; m_err = 0; m_px = 0; m_py = 0; m_step = 0; m_word = '0;
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_word", 32'(out_word), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_step", 32'(out_err_step), 32'd0);

    for (int i = 0; i < 4; i++) send(0, 1, 1);
    chk("idle_ignore", 32'(out_valid), 32'd0);

    for (int v = 0; v < 6; v++) begin
      send(1, vt[v].ox, vt[v].oy);
      for (int j = 0; j < 4; j++) begin
        if (j == 3) chk($sformatf("vec%0d_not_early", v), 32'(out_valid), 32'd0);
        send(0, vt[v].xs[j], vt[v].ys[j]);
      end
      chk($sformatf("vec%0d_valid", v), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_rdy_low", v), 32'(in_ready), 32'd0);
      chk($sformatf("vec%0d_word", v), 32'(out_word), 32'(vt[v].word));
      chk($sformatf("vec%0d_err", v), 32'(out_err), 32'(vt[v].err));
      chk($sformatf("vec%0d_err_step", v), 32'(out_err_step), 32'(vt[v].estep));
      handshake($sformatf("vec%0d", v));
    end

    // Backpressure: held word must not move and offered samples must not be taken.
    send(1, 3, 0); send(0, 4, 1); send(0, 5, 1); send(0, 6, 0); send(0, 6, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 0, 0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_word", 32'(out_word), 32'h29C);
      step();
    end
    chk("bp_still_valid", 32'(out_valid), 32'd1);
    handshake("bp");
    send(0, 7, 1); send(0, 7, 2); send(0, 6, 3); send(0, 5, 4);
    chk("bp_next_word", 32'(out_word), 32'h23F);
    chk("bp_next_err", 32'(out_err), 32'd0);
    handshake("bp2");

    // Restart after two steps discards the partial word.
    send(1, 1, 1); send(0, 2, 2); send(0, 3, 3);
    send(1, 5, 5); send(0, 5, 6); send(0, 6, 7);
    chk("restart_no_early", 32'(out_valid), 32'd0);
    send(0, 7, 7); send(0, 7, 6);
    chk("restart_valid", 32'(out_valid), 32'd1);
    chk("restart_word", 32'(out_word), 32'h04B);
    chk("restart_err", 32'(out_err), 32'd0);
    handshake("restart");

    // Reset while holding a word.
    send(1, 0, 0); for (int i = 0; i < 4; i++) send(0, 0, 0);
    chk("rh_valid", 32'(out_valid), 32'd1);
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rh_vld_low", 32'(out_valid), 32'd0);
    chk("rh_rdy_high", 32'(in_ready), 32'd1);
    chk("rh_word_clr", 32'(out_word), 32'd0);
    chk("rh_err_clr", 32'(out_err), 32'd0);
    for (int i = 0; i < 4; i++) send(0, 1, 1);
    chk("rh_idle_ignore", 32'(out_valid), 32'd0);

    gx = 3; gy = 3;
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 399) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_start  = ($urandom_range(0, 15) == 0);
      out_ready = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 7) == 0) begin
        gx = $urandom_range(0, 7); gy = $urandom_range(0, 7);
      end else begin
        rc = $urandom_range(0, 7);
        gx = clamp7(gx + DX[rc]); gy = clamp7(gy + DY[rc]);
      end
      in_x = 3'(gx); in_y = 3'(gy);
      step();
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
